axi_slave_mem: RTL
==================

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXI and backdoor data width; legal values 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32: AXI and backdoor byte-address width.
REQ-003 Parameter MEM_WORDS, default 4096: memory depth in DATA_WIDTH words; must be a power of two.
REQ-004 clk  in  1  single clock; all logic updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address.
REQ-007 s_axi_awlen  in  8  write beats minus one (INCR burst).
REQ-008 s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
REQ-009 s_axi_wdata  in  DATA_WIDTH  write beat data.
REQ-010 s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
REQ-011 s_axi_wlast  in  1  final-beat marker; ignored, the beat counter governs.
REQ-012 s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
REQ-013 s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake; response implicitly OKAY.
REQ-014 s_axi_araddr  in  ADDR_WIDTH  read burst start byte address.
REQ-015 s_axi_arlen  in  8  read beats minus one (INCR burst).
REQ-016 s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
REQ-017 s_axi_rdata  out  DATA_WIDTH  read beat data.
REQ-018 s_axi_rlast  out  1  high on the final read beat.
REQ-019 s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
REQ-020 bd_en  in  1  backdoor access strobe.
REQ-021 bd_we  in  1  backdoor write (1) or read (0); full-word write.
REQ-022 bd_addr  in  ADDR_WIDTH  backdoor byte address.
REQ-023 bd_wdata / bd_rdata  in / out  DATA_WIDTH  backdoor write data / read data; read data is valid one cycle after bd_en.
REQ-024 init_done  out  1  memory ready; AXI handshakes are refused while this is low.

Function
REQ-025 Word index SHALL be address bits [log2(DATA_WIDTH/8) +: log2(MEM_WORDS)].
  - Higher bits are ignored, so indices wrap modulo MEM_WORDS.
  - Burst beats increment the index by one and wrap silently.
REQ-026 Write FSM SHALL follow W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - awready is high only in W_IDLE with init_done high.
  - wready is high in W_DATA.
  - Transition to W_RESP after beat awlen is accepted.
  - bvalid is held until bready, then return to W_IDLE.
REQ-027 Read FSM SHALL follow R_IDLE -> R_DATA -> R_IDLE.
  - arready is high only in R_IDLE with init_done high.
  - The first rvalid is asserted the cycle after the AR handshake.
  - Beats complete at up to one per cycle while rready is high.
  - rlast is asserted with beat arlen; return to R_IDLE on that beat's handshake.
REQ-028 While rvalid is high and rready is low, rdata and rlast SHALL hold stable.
REQ-029 Byte lanes with wstrb low SHALL retain their prior contents.
REQ-030 A same-cycle backdoor write SHALL take priority over an AXI write beat; wready is driven low that cycle.
REQ-031 A same-cycle read and write to the same index SHALL return the old data (read-first).
REQ-032 Read and write FSMs SHALL operate concurrently and independently.

Reset
REQ-033 While rst_n is low:
  - FSMs go to IDLE; beat counters clear.
  - awready, wready, bvalid, arready, rvalid, rlast, and init_done go to 0.
  - rdata and bd_rdata go to 0.
  - Memory contents are retained.
  - An in-flight burst is abandoned without a response.

Configuration
REQ-034 With AXI_SLAVE_MEM_ADDR_FILL_EN defined:
  - After reset, an init sweep writes each word i with the value i, one word per cycle.
  - init_done rises the cycle after word MEM_WORDS-1 is written.
  - Backdoor writes during the sweep are dropped.
REQ-035 Without AXI_SLAVE_MEM_ADDR_FILL_EN: init_done is 1 the first cycle after rst_n goes high, and no sweep runs.

Structure
REQ-036 Package axi_slave_mem_pkg SHALL hold the write-state and read-state enums and the constant AXI_LEN_W = 8.
REQ-037 Storage SHALL be sub-module axi_slave_mem_ram.
  - One byte-enabled write port, arbitrated init > backdoor > AXI.
  - Two synchronous read ports: AXI and backdoor.

Verification
REQ-038 Backdoor write 0xDEADBEEF at 0x12B0, then backdoor read 0x12B0 -> bd_rdata = 0xDEADBEEF one cycle later.
REQ-039 AXI write of 4 beats at 0x100 with data 1..4, then AXI read arlen=3 -> rdata 1,2,3,4; rlast on beat 4; a single bvalid.
REQ-040 Read arlen=1 at 0x3FFC with MEM_WORDS=4096 -> second beat returns word 0 (wraparound).
REQ-041 Write with wstrb=0x3 and data 0xAAAA5555 over 0xFFFFFFFF -> readback 0xFFFF5555.
REQ-042 With fill enabled, release reset -> init_done rises after 4096 cycles; reading 0x40 returns 0x10.
REQ-043 Hold rready low for 3 cycles mid-burst, and assert rst_n low mid-burst -> rdata stable while stalled; after reset rvalid = 0 and arready returns once init_done is high.

Source files
------------

// File: rtl/axi_slave_mem_pkg.sv
// Shared types for the AXI slave memory: FSM state encodings and burst length width.
package axi_slave_mem_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Word storage: one byte-enabled write port, two synchronous read-first read ports.
module axi_slave_mem_ram #(
  parameter int DW = 32,
  parameter int IW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW/8-1:0] wbe_i,
  input  logic          a_re_i,
  input  logic [IW-1:0] a_idx_i,
  output logic [DW-1:0] a_rdata_o,
  input  logic          b_re_i,
  input  logic [IW-1:0] b_idx_i,
  output logic [DW-1:0] b_rdata_o
);

  logic [DW-1:0] mem_q [2**IW];
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

  // No reset on the array: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wbe_i[i]) mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_re_i) a_q <= mem_q[a_idx_i];
      if (b_re_i) b_q <= mem_q[b_idx_i];
    end
  end

  assign a_rdata_o = a_q;
  assign b_rdata_o = b_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-burst slave memory with backdoor port.
// Optional power-up address fill: define AXI_SLAVE_MEM_ADDR_FILL_EN.
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [AXI_LEN_W-1:0]    s_axi_awlen,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [AXI_LEN_W-1:0]    s_axi_arlen,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic                    bd_en,
  input  logic                    bd_we,
  input  logic [ADDR_WIDTH-1:0]   bd_addr,
  input  logic [DATA_WIDTH-1:0]   bd_wdata,
  output logic [DATA_WIDTH-1:0]   bd_rdata,
  output logic                    init_done
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(SW);
  localparam int IW  = $clog2(MEM_WORDS);

  function automatic logic [IW-1:0] idx_f(input logic [ADDR_WIDTH-1:0] a);
    return a[OFF +: IW];
  endfunction

  wstate_e              ws_q, ws_d;
  logic [IW-1:0]        widx_q, widx_d;
  logic [AXI_LEN_W-1:0] wcnt_q, wcnt_d, wlen_q, wlen_d;
  rstate_e              rs_q, rs_d;
  logic [IW-1:0]        ridx_q, ridx_d;
  logic [AXI_LEN_W-1:0] rcnt_q, rcnt_d, rlen_q, rlen_d;
  logic                 init_done_q;
  logic                 fill_we;
  logic [IW-1:0]        fill_idx;

`ifdef AXI_SLAVE_MEM_ADDR_FILL_EN
  logic [IW-1:0] fill_q;

  // Sweep restarts after every reset; init_done follows the last word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q      <= '0;
      init_done_q <= 1'b0;
    end else if (!init_done_q) begin
      fill_q <= fill_q + IW'(1);
      if (fill_q == IW'(MEM_WORDS - 1)) init_done_q <= 1'b1;
    end
  end

  assign fill_we  = !init_done_q;
  assign fill_idx = fill_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) init_done_q <= 1'b0;
    else        init_done_q <= 1'b1;
  end

  assign fill_we  = 1'b0;
  assign fill_idx = '0;
`endif

  logic bd_wr, aw_hs, w_hs, ar_hs, r_hs;

  assign bd_wr         = bd_en && bd_we;
  assign s_axi_awready = (ws_q == W_IDLE) && init_done_q;
  assign s_axi_wready  = (ws_q == W_DATA) && !bd_wr && !fill_we;
  assign s_axi_bvalid  = (ws_q == W_RESP);
  assign s_axi_arready = (rs_q == R_IDLE) && init_done_q;
  assign s_axi_rvalid  = (rs_q == R_DATA);
  assign s_axi_rlast   = s_axi_rvalid && (rcnt_q == rlen_q);
  assign init_done     = init_done_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;

  always_comb begin
    ws_d   = ws_q;
    widx_d = widx_q;
    wcnt_d = wcnt_q;
    wlen_d = wlen_q;
    unique case (ws_q)
      W_IDLE: if (aw_hs) begin
        ws_d   = W_DATA;
        widx_d = idx_f(s_axi_awaddr);
        wcnt_d = '0;
        wlen_d = s_axi_awlen;
      end
      W_DATA: if (w_hs) begin
        if (wcnt_q == wlen_q) begin
          ws_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q + AXI_LEN_W'(1);
          widx_d = widx_q + IW'(1);
        end
      end
      W_RESP: if (s_axi_bready) ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end

  always_comb begin
    rs_d   = rs_q;
    ridx_d = ridx_q;
    rcnt_d = rcnt_q;
    rlen_d = rlen_q;
    unique case (rs_q)
      R_IDLE: if (ar_hs) begin
        rs_d   = R_DATA;
        ridx_d = idx_f(s_axi_araddr);
        rcnt_d = '0;
        rlen_d = s_axi_arlen;
      end
      R_DATA: if (r_hs) begin
        if (s_axi_rlast) begin
          rs_d = R_IDLE;
        end else begin
          rcnt_d = rcnt_q + AXI_LEN_W'(1);
          ridx_d = ridx_q + IW'(1);
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ws_q   <= W_IDLE;
      widx_q <= '0;
      wcnt_q <= '0;
      wlen_q <= '0;
      rs_q   <= R_IDLE;
      ridx_q <= '0;
      rcnt_q <= '0;
      rlen_q <= '0;
    end else begin
      ws_q   <= ws_d;
      widx_q <= widx_d;
      wcnt_q <= wcnt_d;
      wlen_q <= wlen_d;
      rs_q   <= rs_d;
      ridx_q <= ridx_d;
      rcnt_q <= rcnt_d;
      rlen_q <= rlen_d;
    end
  end

  logic                  ram_we;
  logic [IW-1:0]         ram_widx;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [SW-1:0]         ram_wbe;

  // Write port priority: init sweep, then backdoor, then AXI beat.
  always_comb begin
    ram_we    = rst_n && (fill_we || bd_wr || w_hs);
    ram_widx  = widx_q;
    ram_wdata = s_axi_wdata;
    ram_wbe   = s_axi_wstrb;
    if (fill_we) begin
      ram_widx  = fill_idx;
      ram_wdata = DATA_WIDTH'(fill_idx);
      ram_wbe   = '1;
    end else if (bd_wr) begin
      ram_widx  = idx_f(bd_addr);
      ram_wdata = bd_wdata;
      ram_wbe   = '1;
    end
  end

  // ridx_d is the index of whichever beat becomes current next.
  axi_slave_mem_ram #(
    .DW (DATA_WIDTH),
    .IW (IW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (ram_we),
    .widx_i    (ram_widx),
    .wdata_i   (ram_wdata),
    .wbe_i     (ram_wbe),
    .a_re_i    (ar_hs || (r_hs && !s_axi_rlast)),
    .a_idx_i   (ridx_d),
    .a_rdata_o (s_axi_rdata),
    .b_re_i    (bd_en && !bd_we),
    .b_idx_i   (idx_f(bd_addr)),
    .b_rdata_o (bd_rdata)
  );

  logic unused_ok;
  assign unused_ok = ^{s_axi_wlast, s_axi_awaddr, s_axi_araddr, bd_addr};

endmodule
